// File: rtl/frng_sched_pkg.sv
// Shared types and helpers for the fringe put scheduler.
// put_data follows the shunt_fringe_pkg data_in_t layout; the put adapter maps it onto data_bit.
package frng_sched_pkg;

  localparam int unsigned SCHED_CNT_W = 16;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_SEND = 1'b1
  } sched_state_e;

  // Round-robin pointer moves to the slot after the one just served.
  function automatic int unsigned sched_next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/frng_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module frng_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base, input int unsigned off);
    int unsigned c;
    c = 32'(base) + off;
    if (c >= N) c = c - N;
    return IDX_W'(c);
  endfunction

  // Scan from the far end so the nearest request to ptr wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (req[rot(ptr, k - 1)]) begin
        grant_valid = 1'b1;
        grant_idx   = rot(ptr, k - 1);
      end
    end
  end

endmodule

// File: rtl/frng_put_scheduler.sv
// Serializes changed/refreshed source signals onto a single put channel,
// one put per handshake, round-robin across pending sources.
module frng_put_scheduler
  import frng_sched_pkg::*;
#(
  parameter  int unsigned N_SRC        = 4,
  parameter  int unsigned DATA_W       = 32,
  parameter  int unsigned FORCE_PERIOD = 16,
  localparam int unsigned IDX_W        = $clog2(N_SRC)
) (
  input  logic                    i_clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_en,
  input  logic                    sync_req,
  output logic                    put_valid,
  input  logic                    put_ready,
  output logic [IDX_W-1:0]        put_idx,
  output logic [DATA_W-1:0]       put_data,
  output logic                    busy,
  output logic [SCHED_CNT_W-1:0]  sent_cnt
);

  sched_state_e            state, state_d;
  logic [N_SRC-1:0]        pending, pending_d;
  logic [DATA_W-1:0]       last_sent [N_SRC];
  logic [DATA_W-1:0]       src_vec   [N_SRC];
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_d;
  logic                    init_flag;
  logic                    put_valid_d;
  logic [IDX_W-1:0]        put_idx_d;
  logic [DATA_W-1:0]       put_data_d;
  logic [SCHED_CNT_W-1:0]  sent_cnt_d;
  logic                    hs;
  logic [N_SRC-1:0]        hs_vec;
  logic                    refresh_tick;
  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;

  assign hs   = put_valid && put_ready;
  assign busy = (state == SCHED_SEND) || (|pending);

  always_comb begin
    for (int i = 0; i < int'(N_SRC); i++) src_vec[i] = src_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    hs_vec = '0;
    if (hs) hs_vec[put_idx] = 1'b1;
  end

  generate
    if (FORCE_PERIOD == 0) begin : g_no_refresh
      assign refresh_tick = 1'b0;
    end else begin : g_refresh
      localparam int unsigned REF_W = (FORCE_PERIOD > 1) ? $clog2(FORCE_PERIOD) : 1;
      logic [REF_W-1:0] refresh_cnt;
      assign refresh_tick = (refresh_cnt == REF_W'(FORCE_PERIOD - 1));
      always_ff @(posedge i_clk) begin
        if (reset || refresh_tick) refresh_cnt <= '0;
        else                       refresh_cnt <= refresh_cnt + REF_W'(1);
      end
    end
  endgenerate

  // The value being accepted this cycle is the reference for its own change detect,
  // so a handshake does not re-trigger itself; set still beats clear.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      pending_d[i] = src_en[i] &&
                     (init_flag || sync_req || refresh_tick ||
                      (src_vec[i] != (hs_vec[i] ? put_data : last_sent[i])) ||
                      (pending[i] && !hs_vec[i]));
    end
  end

  frng_rr_arbiter #(.N(N_SRC)) u_arb (
    .req         (pending & src_en),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d     = state;
    put_valid_d = put_valid;
    put_idx_d   = put_idx;
    put_data_d  = put_data;
    rr_ptr_d    = rr_ptr;
    sent_cnt_d  = sent_cnt;
    case (state)
      SCHED_IDLE: begin
        if (grant_valid) begin
          put_valid_d = 1'b1;
          put_idx_d   = grant_idx;
          put_data_d  = src_vec[grant_idx];
          state_d     = SCHED_SEND;
        end
      end
      SCHED_SEND: begin
        if (hs) begin
          put_valid_d = 1'b0;
          rr_ptr_d    = IDX_W'(sched_next_ptr(32'(put_idx), N_SRC));
          sent_cnt_d  = sent_cnt + SCHED_CNT_W'(1);
          state_d     = SCHED_IDLE;
        end
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state     <= SCHED_IDLE;
      put_valid <= 1'b0;
      put_idx   <= '0;
      put_data  <= '0;
      rr_ptr    <= '0;
      sent_cnt  <= '0;
      pending   <= '0;
      init_flag <= 1'b1;
      for (int i = 0; i < int'(N_SRC); i++) last_sent[i] <= '0;
    end else begin
      state     <= state_d;
      put_valid <= put_valid_d;
      put_idx   <= put_idx_d;
      put_data  <= put_data_d;
      rr_ptr    <= rr_ptr_d;
      sent_cnt  <= sent_cnt_d;
      pending   <= pending_d;
      init_flag <= 1'b0;
      if (hs) last_sent[put_idx] <= put_data;
    end
  end

endmodule

// File: tb/tb_frng_put_scheduler.sv
// Bench for frng_put_scheduler: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_frng_put_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int FP = 16;

  logic              i_clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     tb_data [N];
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_en;
  logic              sync_req;
  logic              put_ready;
  logic              put_valid, put_valid0;
  logic [1:0]        put_idx, put_idx0;
  logic [DW-1:0]     put_data, put_data0;
  logic              busy, busy0;
  logic [15:0]       sent_cnt, sent_cnt0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int            hs_idx[$];
  logic [DW-1:0] hs_data[$];
  int            hs_cyc[$];
  int            hs0_idx[$];
  logic [DW-1:0] hs0_data[$];

  // Reference model state (FORCE_PERIOD = FP instance)
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_last [N];
  int            m_ptr, m_idx, m_cnt, m_rcnt;
  logic          m_valid, m_init;
  logic [DW-1:0] m_data;

  assign src_data = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};

  always #5 i_clk = ~i_clk;

  frng_put_scheduler #(.N_SRC(N), .DATA_W(DW), .FORCE_PERIOD(FP)) dut (
    .i_clk(i_clk), .reset(reset), .src_data(src_data), .src_en(src_en),
    .sync_req(sync_req), .put_valid(put_valid), .put_ready(put_ready),
    .put_idx(put_idx), .put_data(put_data), .busy(busy), .sent_cnt(sent_cnt)
  );

  frng_put_scheduler #(.N_SRC(N), .DATA_W(DW), .FORCE_PERIOD(0)) dut0 (
    .i_clk(i_clk), .reset(reset), .src_data(src_data), .src_en(src_en),
    .sync_req(sync_req), .put_valid(put_valid0), .put_ready(put_ready),
    .put_idx(put_idx0), .put_data(put_data0), .busy(busy0), .sent_cnt(sent_cnt0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs the DUT sees.
  task automatic model_step();
    logic [N-1:0] np;
    logic         hs, tick;
    logic [DW-1:0] ref_v;
    int           win, j;
    if (reset) begin
      m_pend = '0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_rcnt = 0;
      m_valid = 1'b0; m_init = 1'b1; m_data = '0;
      for (int i = 0; i < N; i++) m_last[i] = '0;
      return;
    end
    hs   = m_valid && put_ready;
    tick = (FP != 0) && (m_rcnt == FP - 1);
    for (int i = 0; i < N; i++) begin
      ref_v = (hs && m_idx == i) ? m_data : m_last[i];
      np[i] = src_en[i] && (m_init || sync_req || tick || tb_data[i] != ref_v ||
                            (m_pend[i] && !(hs && m_idx == i)));
    end
    if (hs) begin
      m_last[m_idx] = m_data;
      m_ptr   = (m_idx + 1) % N;
      m_cnt   = (m_cnt + 1) % 65536;
      m_valid = 1'b0;
    end else if (!m_valid) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (win < 0 && m_pend[j] && src_en[j]) win = j;
      end
      if (win >= 0) begin
        m_valid = 1'b1;
        m_idx   = win;
        m_data  = tb_data[win];
      end
    end
    m_rcnt = (FP == 0) ? 0 : (m_rcnt + 1) % FP;
    m_init = 1'b0;
    m_pend = np;
  endtask

  task automatic tick_cycle();
    if (put_valid === 1'b1 && put_ready) begin
      hs_idx.push_back(int'(put_idx)); hs_data.push_back(put_data); hs_cyc.push_back(cyc);
    end
    if (put_valid0 === 1'b1 && put_ready) begin
      hs0_idx.push_back(int'(put_idx0)); hs0_data.push_back(put_data0);
    end
    @(posedge i_clk);
    cyc++;
    model_step();
    #1;
    check("put_valid", put_valid, m_valid);
    check("put_idx",   put_idx,   m_idx);
    check("put_data",  put_data,  m_data);
    check("sent_cnt",  sent_cnt,  m_cnt);
    check("busy",      busy,      m_valid || (|m_pend));
  endtask

  task automatic clear_logs();
    hs_idx.delete(); hs_data.delete(); hs_cyc.delete(); hs0_idx.delete(); hs0_data.delete();
  endtask

  task automatic check_order(input string tag, input bit which0, input int n,
                             input int e0, input int e1, input int e2, input int e3);
    int exp_a[4];
    int got_n, got;
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
    got_n = which0 ? hs0_idx.size() : hs_idx.size();
    check({tag, "_count"}, got_n, n);
    for (int j = 0; j < n; j++) begin
      if (j < got_n) got = which0 ? hs0_idx[j] : hs_idx[j];
      else           got = -1;
      check($sformatf("%s_idx%0d", tag, j), got, exp_a[j]);
    end
  endtask

  initial begin
    reset = 1'b1; src_en = 4'b1011; sync_req = 1'b0; put_ready = 1'b1;
    for (int i = 0; i < N; i++) tb_data[i] = '0;
    repeat (3) tick_cycle();

    // Initial sync after reset: 0,1,3 with zero data, then quiet
    clear_logs();
    reset = 1'b0;
    repeat (8) tick_cycle();
    check_order("t1", 1'b0, 3, 0, 1, 3, 0);
    for (int j = 0; j < 3; j++) check("t1_data", (j < hs_data.size()) ? hs_data[j] : 32'hdead, 0);
    check("t1_sent_cnt", sent_cnt, 3);
    check("t1_busy", busy, 0);

    // Stalled put of idx 2 keeps 0x5 while the source moves to 0x6
    src_en = 4'b0100; put_ready = 1'b0; tb_data[2] = 32'h5;
    repeat (2) tick_cycle();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) tb_data[2] = 32'h6;
      tick_cycle();
      check("t2_hold_valid", put_valid, 1);
      check("t2_hold_data", put_data, 32'h5);
    end
    clear_logs();
    put_ready = 1'b1;
    repeat (6) tick_cycle();
    check_order("t2", 1'b0, 2, 2, 2, 0, 0);
    check("t2_data0", (hs_data.size() > 0) ? hs_data[0] : 32'hdead, 32'h5);
    check("t2_data1", (hs_data.size() > 1) ? hs_data[1] : 32'hdead, 32'h6);

    // Periodic refresh on idx 0; the FORCE_PERIOD=0 instance stays silent
    src_en = 4'b0001;
    repeat (20) tick_cycle();
    clear_logs();
    repeat (48) tick_cycle();
    check("t3_count", hs_idx.size(), 3);
    for (int j = 0; j < hs_idx.size(); j++) check("t3_idx", hs_idx[j], 0);
    for (int j = 1; j < hs_cyc.size(); j++) check("t3_period", hs_cyc[j] - hs_cyc[j-1], 16);
    check("t3_fp0_count", hs0_idx.size(), 0);
    check("t3_fp0_busy", busy0, 0);

    // Round-robin order on the no-refresh instance
    reset = 1'b1; src_en = 4'b1111;
    repeat (2) tick_cycle();
    reset = 1'b0;
    repeat (10) tick_cycle();
    clear_logs();
    tb_data[0] = 32'h11; tb_data[1] = 32'h22; tb_data[2] = 32'h33; tb_data[3] = 32'h44;
    repeat (10) tick_cycle();
    check_order("t4a", 1'b1, 4, 0, 1, 2, 3);
    clear_logs();
    tb_data[0] = 32'h55; tb_data[2] = 32'h66;
    repeat (8) tick_cycle();
    check_order("t4b", 1'b1, 2, 0, 2, 0, 0);

    // Reset in the middle of a stalled put, then a fresh initial sync
    put_ready = 1'b0; tb_data[1] = 32'h77;
    repeat (3) tick_cycle();
    check("t5_pre_valid0", put_valid0, 1);
    reset = 1'b1;
    tick_cycle();
    check("t5_valid", put_valid, 0);
    check("t5_cnt", sent_cnt, 0);
    check("t5_valid0", put_valid0, 0);
    check("t5_cnt0", sent_cnt0, 0);
    reset = 1'b0; put_ready = 1'b1;
    clear_logs();
    repeat (10) tick_cycle();
    check_order("t5_fp0", 1'b1, 4, 0, 1, 2, 3);
    check_order("t5_fp16", 1'b0, 4, 0, 1, 2, 3);
    for (int j = 0; j < 4; j++)
      check("t5_data", (j < hs0_data.size()) ? hs0_data[j] : 32'hdead, tb_data[j]);

    // Host sync request with two enabled sources
    src_en = 4'b0110;
    repeat (12) tick_cycle();
    clear_logs();
    sync_req = 1'b1;
    tick_cycle();
    sync_req = 1'b0;
    repeat (8) tick_cycle();
    check_order("t6", 1'b1, 2, 1, 2, 0, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) src_en = 4'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) tb_data[i] = 32'($urandom_range(0, 3));
      sync_req  = ($urandom_range(0, 19) == 0);
      put_ready = ($urandom_range(0, 2) != 0);
      tick_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
